ibex_rf_erase_ctrl: RTL and testbench



---
 rtl/ibex_rf_erase_ctrl.sv | 127 ++++++++++++
 tb/tb_ibex_rf_erase_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_erase_ctrl.sv
// ----------------------------------------------------------------------------
// ibex_rf_erase_ctrl
//
// Secure-erase sequencer for the index-list (renamed) register file. An erase
// request carries a mask of architectural registers. Once the request is
// accepted, the block issues one per-register erase strobe per cycle, lowest
// index first. Core write-port activity is observed so that a register that
// has just been written is never erased: a write already retires the old
// physical register, so the written register simply leaves the pending set.
//
// Parameters
//   RV32E        1: 16 architectural registers, 0: 32 registers
//
// Ports
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   ers_req_i    erase request, held high until acknowledged
//   ers_mask_i   registers to erase (bit 0 and bits >= NUM_WORDS ignored)
//   ers_ack_o    request accepted this cycle
//   ers_done_o   one-cycle pulse once every accepted register is handled
//   busy_o       request in progress (ERASE or DONE)
//   erase_cnt_o  erase strobes issued for the current or last request
//   we_a_i       core register-file write enable (observed only)
//   waddr_a_i    core register-file write address (observed only)
//   sec_ers_o    one-hot (or zero) erase vector to the register file
// ----------------------------------------------------------------------------
module ibex_rf_erase_ctrl #(
   parameter bit RV32E = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ers_req_i,
   input  logic [31:0] ers_mask_i,
   output logic        ers_ack_o,
   output logic        ers_done_o,
   output logic        busy_o,
   output logic [5:0]  erase_cnt_o,
   input  logic        we_a_i,
   input  logic [4:0]  waddr_a_i,
   output logic [31:0] sec_ers_o
);

   // x0 is hard-wired to zero and never holds data, so it is never erased.
   localparam logic [31:0] VALID_MASK = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pending;
   logic [5:0]  r_erase_cnt;

   logic [31:0] w_wr_hit;
   logic [31:0] w_sel_oh;
   logic        w_sel_hit;
   logic [31:0] w_pending_ack;
   logic [31:0] w_pending_ers;

   // One-hot of the register being written this cycle, restricted to
   // registers that can ever be pending.
   always_comb begin
      w_wr_hit = '0;
      if (we_a_i) begin
         w_wr_hit[waddr_a_i] = 1'b1;
      end
      w_wr_hit = w_wr_hit & VALID_MASK;
   end

   // Two's-complement trick isolates the lowest set bit of the pending set.
   assign w_sel_oh      = r_pending & (~r_pending + 32'd1);
   assign w_sel_hit     = |(w_sel_oh & w_wr_hit);
   assign w_pending_ack = ers_mask_i & VALID_MASK & ~w_wr_hit;
   assign w_pending_ers = r_pending & ~w_sel_oh & ~w_wr_hit;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_pending   <= '0;
         r_erase_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ers_req_i) begin
                  r_pending   <= w_pending_ack;
                  r_erase_cnt <= '0;
                  r_state     <= (w_pending_ack != '0) ? ERASE : DONE;
               end
            end
            ERASE: begin
               r_pending <= w_pending_ers;
               // A write to the selected register costs the cycle without a strobe.
               if (!w_sel_hit) begin
                  r_erase_cnt <= r_erase_cnt + 6'd1;
               end
               if (w_pending_ers == '0) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state   <= IDLE;
               r_pending <= '0;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state plus the live write port so a
   // same-cycle core write suppresses the strobe immediately.
   always_comb begin
      ers_ack_o  = (r_state == IDLE) && ers_req_i;
      ers_done_o = (r_state == DONE);
      busy_o     = (r_state != IDLE);
      sec_ers_o  = '0;
      if ((r_state == ERASE) && !w_sel_hit) begin
         sec_ers_o = w_sel_oh;
      end
   end

   assign erase_cnt_o = r_erase_cnt;

endmodule

// File: tb/tb_ibex_rf_erase_ctrl.sv
module tb_ibex_rf_erase_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] mask = '0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;

   logic        ack0, done0, busy0, ack1, done1, busy1;
   logic [5:0]  cnt0, cnt1;
   logic [31:0] sec0, sec1;

   int total = 0;
   int bad   = 0;

   // Per-cycle write schedule relative to the ack cycle (index 0).
   logic        we_tab   [0:63];
   logic [4:0]  addr_tab [0:63];
   // Expected strobes per DUT (0: 32 regs, 1: 16 regs).
   logic [31:0] exp_s [0:1][0:63];
   int          exp_n [0:1];
   int          exp_c [0:1];

   always #5 clk = ~clk;

   ibex_rf_erase_ctrl #(.RV32E(1'b0)) dut (
      .clk_i(clk), .rst_i(rst), .ers_req_i(req), .ers_mask_i(mask),
      .ers_ack_o(ack0), .ers_done_o(done0), .busy_o(busy0), .erase_cnt_o(cnt0),
      .we_a_i(we), .waddr_a_i(waddr), .sec_ers_o(sec0));

   ibex_rf_erase_ctrl #(.RV32E(1'b1)) dut_e (
      .clk_i(clk), .rst_i(rst), .ers_req_i(req), .ers_mask_i(mask),
      .ers_ack_o(ack1), .ers_done_o(done1), .busy_o(busy1), .erase_cnt_o(cnt1),
      .we_a_i(we), .waddr_a_i(waddr), .sec_ers_o(sec1));

   task automatic clear_tab();
      for (int i = 0; i < 64; i++) begin
         we_tab[i]   = 1'b0;
         addr_tab[i] = '0;
      end
   endtask

   // Reference: pending is a set of register numbers; each cycle the smallest
   // one is visited, and any register written that cycle leaves the set.
   task automatic model(input int d, input int nw, input logic [31:0] m);
      bit pend [0:31];
      int c, sel, cnt;
      bit any;
      for (int k = 0; k < 32; k++) pend[k] = (k >= 1) && (k < nw) && m[k];
      if (we_tab[0]) pend[addr_tab[0]] = 1'b0;
      c = 1;
      cnt = 0;
      forever begin
         any = 1'b0;
         sel = 0;
         for (int k = 31; k >= 1; k--) if (pend[k]) begin sel = k; any = 1'b1; end
         if (!any) break;
         if (we_tab[c] && addr_tab[c] == 5'(sel)) begin
            exp_s[d][c] = '0;
         end else begin
            exp_s[d][c] = 32'd1 << sel;
            cnt++;
         end
         pend[sel] = 1'b0;
         if (we_tab[c]) pend[addr_tab[c]] = 1'b0;
         c++;
      end
      exp_n[d] = c - 1;
      exp_c[d] = cnt;
   endtask

   task automatic run_txn(input logic [31:0] m, input string name);
      int last;
      logic [31:0] s_v;
      logic d_v, b_v, a_v;
      logic [5:0] c_v;
      logic [31:0] es;
      logic ed, eb;
      model(0, 32, m);
      model(1, 16, m);
      @(negedge clk);
      req = 1'b1; mask = m; we = we_tab[0]; waddr = addr_tab[0];
      #1;
      total++;
      if (ack0 !== 1'b1 || ack1 !== 1'b1) begin
         bad++;
         $display("FAIL %s ack got=%b/%b exp=1/1", name, ack0, ack1);
      end
      last = ((exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1]) + 2;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         req = 1'b0; we = we_tab[c]; waddr = addr_tab[c];
         #1;
         for (int d = 0; d < 2; d++) begin
            s_v = d ? sec1 : sec0;
            d_v = d ? done1 : done0;
            b_v = d ? busy1 : busy0;
            a_v = d ? ack1 : ack0;
            c_v = d ? cnt1 : cnt0;
            if (c <= exp_n[d]) begin
               es = exp_s[d][c]; ed = 1'b0; eb = 1'b1;
            end else if (c == exp_n[d] + 1) begin
               es = '0; ed = 1'b1; eb = 1'b1;
            end else begin
               es = '0; ed = 1'b0; eb = 1'b0;
            end
            total++;
            if (s_v !== es || d_v !== ed || b_v !== eb || a_v !== 1'b0) begin
               bad++;
               $display("FAIL %s d=%0d c=%0d sec/done/busy/ack got=%h/%b/%b/%b exp=%h/%b/%b/0",
                        name, d, c, s_v, d_v, b_v, a_v, es, ed, eb);
            end
            if (c == exp_n[d] + 1) begin
               total++;
               if (c_v !== 6'(exp_c[d])) begin
                  bad++;
                  $display("FAIL %s d=%0d erase_cnt got=%0d exp=%0d", name, d, c_v, exp_c[d]);
               end
            end
         end
      end
      we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({ack0, done0, busy0, cnt0, sec0} !== '0 || {ack1, done1, busy1, cnt1, sec1} !== '0) begin
         bad++;
         $display("FAIL reset outputs got=%b%b%b %0d %h / %b%b%b %0d %h exp=all zero",
                  ack0, done0, busy0, cnt0, sec0, ack1, done1, busy1, cnt1, sec1);
      end
   endtask

   task automatic test_basic();
      clear_tab();
      run_txn(32'h0000_0016, "basic");
      // Independent spot check of the spec example: three strobes.
      total++;
      if (exp_n[0] != 3 || exp_s[0][1] != 32'h2 || exp_s[0][2] != 32'h4 || exp_s[0][3] != 32'h10
          || cnt0 !== 6'd3) begin
         bad++;
         $display("FAIL basic_seq cnt got=%0d exp=3", cnt0);
      end
   endtask

   task automatic test_empty();
      clear_tab();
      run_txn(32'h0000_0001, "r0_empty");
      clear_tab();
      run_txn(32'h0000_0000, "zero_mask");
   endtask

   task automatic test_write_conflict();
      clear_tab();
      we_tab[1] = 1'b1; addr_tab[1] = 5'd2;
      run_txn(32'h0000_000C, "wr_conflict");
      clear_tab();
      we_tab[0] = 1'b1; addr_tab[0] = 5'd3;
      run_txn(32'h0000_000C, "wr_at_ack");
   endtask

   task automatic test_later_write();
      clear_tab();
      we_tab[1] = 1'b1; addr_tab[1] = 5'd31;
      run_txn(32'hF000_0000, "later_write");
   endtask

   task automatic test_full_mask();
      clear_tab();
      run_txn(32'hFFFF_FFFF, "full_mask");
      total++;
      if (cnt1 !== 6'd15 || cnt0 !== 6'd31) begin
         bad++;
         $display("FAIL full_mask_cnt got=%0d/%0d exp=31/15", cnt0, cnt1);
      end
   endtask

   task automatic test_random();
      logic [31:0] m;
      for (int it = 0; it < 20; it++) begin
         clear_tab();
         for (int c = 0; c < 64; c++) begin
            we_tab[c]   = ($urandom_range(0, 2) == 0);
            addr_tab[c] = 5'($urandom_range(0, 31));
         end
         m = (it % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
         run_txn(m, "random");
      end
   endtask

   task automatic test_reset_mid();
      clear_tab();
      @(negedge clk);
      req = 1'b1; mask = 32'h0000_003E; we = 1'b0;
      @(negedge clk);
      req = 1'b0;
      #1;
      total++;
      if (sec0 !== 32'h2 || sec1 !== 32'h2) begin
         bad++;
         $display("FAIL rst_mid strobe1 got=%h/%h exp=2", sec0, sec1);
      end
      @(negedge clk);
      #1;
      total++;
      if (sec0 !== 32'h4 || sec1 !== 32'h4) begin
         bad++;
         $display("FAIL rst_mid strobe2 got=%h/%h exp=4", sec0, sec1);
      end
      @(negedge clk);
      #1;
      total++;
      if (cnt0 !== 6'd2 || cnt1 !== 6'd2) begin
         bad++;
         $display("FAIL rst_mid cnt got=%0d/%0d exp=2", cnt0, cnt1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if ({ack0, done0, busy0, cnt0, sec0} !== '0 || {ack1, done1, busy1, cnt1, sec1} !== '0) begin
         bad++;
         $display("FAIL rst_mid outputs got=%b%b%b %0d %h exp=all zero", ack0, done0, busy0, cnt0, sec0);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         total++;
         if (done0 !== 1'b0 || done1 !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid no_done c=%0d done=%b/%b busy=%b exp=0", c, done0, done1, busy0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ea;
      int ndone;
      @(negedge clk);
      req = 1'b1; mask = 32'h0000_0006; we = 1'b0;
      // Two strobes: ack at 0, ERASE 1..2, DONE 3, next ack at 4.
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         ea = (c == 0 || c == 4);
         total++;
         if (ack0 !== ea || ack1 !== ea) begin
            bad++;
            $display("FAIL b2b ack c=%0d got=%b/%b exp=%b", c, ack0, ack1, ea);
         end
      end
      @(negedge clk);
      req = 1'b0;
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (done0 === 1'b1) ndone++;
         @(negedge clk);
      end
      total++;
      if (ndone != 1) begin
         bad++;
         $display("FAIL b2b second_done count got=%0d exp=1", ndone);
      end
   endtask

   initial begin
      clear_tab();
      test_reset();
      test_basic();
      test_empty();
      test_write_conflict();
      test_later_write();
      test_full_mask();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
